// File: rtl/key_mdio_sequencer_pkg.sv
// Shared types and constants for the key/poll MDIO sequencer.
// Holds the FSM state type, MDIO opcodes, PHY register map and config ROM.
package mdio_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DONE,
      ST_NEXT
   } seq_state_t;

   localparam logic OP_READ  = 1'b1;
   localparam logic OP_WRITE = 1'b0;

   localparam logic [4:0] REG_BMCR = 5'd0;
   localparam logic [4:0] REG_BMSR = 5'd1;
   localparam logic [4:0] REG_ANAR = 5'd4;

   typedef struct packed {
      logic        op;
      logic [4:0]  reg_addr;
      logic [15:0] data;
   } mdio_cmd_t;

   localparam int ROM_DEPTH = 4;

   // Soft reset, advertise 10/100 FD/HD, restart AN, then read status.
   localparam mdio_cmd_t CFG_ROM [0:ROM_DEPTH-1] = '{
      '{OP_WRITE, REG_BMCR, 16'h8000},
      '{OP_WRITE, REG_ANAR, 16'h01E1},
      '{OP_WRITE, REG_BMCR, 16'h1200},
      '{OP_READ,  REG_BMSR, 16'h0000}
   };

   // Status read: any read of BMSR refreshes the published link status.
   function automatic logic is_status_read(
      input logic       op,
      input logic [4:0] reg_addr
   );
      return (op == OP_READ) && (reg_addr == REG_BMSR);
   endfunction

endpackage

// File: rtl/key_mdio_sequencer_poll_timer.sv
// Free-running poll timer for the MDIO sequencer.
// Counts 0..POLL_MAX and flags the terminal count for one cycle.
module poll_timer #(
   parameter logic [25:0] POLL_MAX = 26'd49_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic tc
);

   logic [25:0] count;

   assign tc = (count == POLL_MAX);

   // Count every cycle, wrapping from the terminal count to zero.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         count <= 26'd0;
      end else if (tc) begin
         count <= 26'd0;
      end else begin
         count <= count + 26'd1;
      end
   end

endmodule

// File: rtl/key_mdio_sequencer.sv
// Arbitrates key-launched PHY config and periodic status polls
// onto one MDIO master request/ack/done handshake.
module key_mdio_sequencer
   import mdio_seq_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR = 5'd1,
   parameter logic [25:0] POLL_MAX = 26'd49_999_999,
   parameter logic [2:0]  SEQ_LEN  = 3'd4
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        key_flag,
   output logic        mdio_req,
   output logic        mdio_op,
   output logic [4:0]  mdio_phy_addr,
   output logic [4:0]  mdio_reg_addr,
   output logic [15:0] mdio_wdata,
   input  logic        mdio_ack,
   input  logic        mdio_done,
   input  logic [15:0] mdio_rdata,
   output logic        busy,
   output logic        status_valid,
   output logic [15:0] status_data,
   output logic        link_up
);

   seq_state_t state;

   logic       cfg_pend;
   logic       poll_pend;
   logic       cfg_active;
   logic [2:0] step;
   logic [2:0] step_nx;
   logic       poll_tc;
   logic       seq_more;
   logic       cfg_launch;
   logic       poll_launch;
   logic       key_accept;
   mdio_cmd_t  rom_first;
   mdio_cmd_t  rom_next;

   poll_timer #(
      .POLL_MAX (POLL_MAX)
   ) u_poll_timer (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tc      (poll_tc)
   );

   assign step_nx   = step + 3'd1;
   assign rom_first = CFG_ROM[0];
   assign rom_next  = CFG_ROM[step_nx[1:0]];

   assign seq_more = cfg_active
                  && (step < (SEQ_LEN - 3'd1));

   assign cfg_launch  = (state == ST_IDLE)
                     && cfg_pend;
   assign poll_launch = (state == ST_IDLE)
                     && !cfg_pend
                     && poll_pend;

   // A key is taken unless a sequence is running; the
   // final NEXT cycle already counts as finished.
   assign key_accept = key_flag
                    && (!cfg_active
                        || ((state == ST_NEXT)
                            && !seq_more));

   assign mdio_phy_addr = PHY_ADDR;
   assign busy          = (state != ST_IDLE);
   assign link_up       = status_data[2];

   // Pending-source latches; poll terminal counts do not stack.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cfg_pend  <= 1'b0;
         poll_pend <= 1'b0;
      end else begin
         if (cfg_launch) begin
            cfg_pend <= 1'b0;
         end else if (key_accept) begin
            cfg_pend <= 1'b1;
         end
         if (poll_tc) begin
            poll_pend <= 1'b1;
         end else if (poll_launch) begin
            poll_pend <= 1'b0;
         end
      end
   end

   // Sequencer FSM with registered MDIO and status outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state         <= ST_IDLE;
         step          <= 3'd0;
         cfg_active    <= 1'b0;
         mdio_req      <= 1'b0;
         mdio_op       <= 1'b0;
         mdio_reg_addr <= 5'd0;
         mdio_wdata    <= 16'h0000;
         status_valid  <= 1'b0;
         status_data   <= 16'h0000;
      end else begin
         status_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cfg_pend) begin
                  step          <= 3'd0;
                  cfg_active    <= 1'b1;
                  mdio_op       <= rom_first.op;
                  mdio_reg_addr <= rom_first.reg_addr;
                  mdio_wdata    <= rom_first.data;
                  mdio_req      <= 1'b1;
                  state         <= ST_REQ;
               end else if (poll_pend) begin
                  mdio_op       <= OP_READ;
                  mdio_reg_addr <= REG_BMSR;
                  mdio_wdata    <= 16'h0000;
                  mdio_req      <= 1'b1;
                  state         <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mdio_ack) begin
                  mdio_req <= 1'b0;
                  state    <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (mdio_done) begin
                  if (is_status_read(mdio_op,
                                     mdio_reg_addr)) begin
                     status_data  <= mdio_rdata;
                     status_valid <= 1'b1;
                  end
                  state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (seq_more) begin
                  step          <= step_nx;
                  mdio_op       <= rom_next.op;
                  mdio_reg_addr <= rom_next.reg_addr;
                  mdio_wdata    <= rom_next.data;
                  mdio_req      <= 1'b1;
                  state         <= ST_REQ;
               end else begin
                  cfg_active <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_mdio_sequencer.sv
// Self-checking bench for key_mdio_sequencer.
// A behavioural MDIO master answers requests; a model predicts them.
module tb_key_mdio_sequencer;

   localparam logic [25:0] PMAX = 26'd100;
   localparam int PER = int'(PMAX) + 1;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        key_flag = 1'b0;
   logic        mdio_ack = 1'b0;
   logic        mdio_done = 1'b0;
   logic [15:0] mdio_rdata = 16'h0000;
   logic        mdio_req;
   logic        mdio_op;
   logic [4:0]  mdio_phy_addr;
   logic [4:0]  mdio_reg_addr;
   logic [15:0] mdio_wdata;
   logic        busy;
   logic        status_valid;
   logic [15:0] status_data;
   logic        link_up;

   int total = 0;
   int bad = 0;
   int ecount = 0;

   int ack_dly = 2;
   int done_dly = 10;
   logic [15:0] rd_val = 16'h0000;
   bit spur = 1'b0;
   int rs = 0;
   int cnt = 0;

   logic [26:0] acks[$];
   logic [26:0] exp_q[$];
   int rise_q[$];
   int done_q[$];
   int width_q[$];
   int viol = 0;
   int sv_cnt = 0;
   int sv_bad = 0;
   logic prev_req = 1'b0;
   logic [26:0] hold = '0;
   int w = 0;

   key_mdio_sequencer #(
      .PHY_ADDR (5'd1),
      .POLL_MAX (PMAX),
      .SEQ_LEN  (3'd4)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .key_flag      (key_flag),
      .mdio_req      (mdio_req),
      .mdio_op       (mdio_op),
      .mdio_phy_addr (mdio_phy_addr),
      .mdio_reg_addr (mdio_reg_addr),
      .mdio_wdata    (mdio_wdata),
      .mdio_ack      (mdio_ack),
      .mdio_done     (mdio_done),
      .mdio_rdata    (mdio_rdata),
      .busy          (busy),
      .status_valid  (status_valid),
      .status_data   (status_data),
      .link_up       (link_up)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (sys_rst) ecount <= 0;
      else ecount <= ecount + 1;
   end

   // Behavioural MDIO master: ack after ack_dly, done after done_dly.
   initial forever begin
      @(negedge sys_clk);
      mdio_ack = 1'b0;
      mdio_done = 1'b0;
      if (sys_rst) begin
         rs = 0;
         spur = 1'b0;
      end else begin
         if (spur) begin
            mdio_done = 1'b1;
            spur = 1'b0;
         end
         case (rs)
            0: if (mdio_req) begin
               cnt = ack_dly;
               rs = 1;
            end
            default: ;
         endcase
         if (rs == 1) begin
            if (cnt == 0) begin
               mdio_ack = 1'b1;
               acks.push_back({mdio_op, mdio_reg_addr,
                               mdio_wdata, mdio_phy_addr});
               cnt = done_dly;
               rs = 2;
            end else begin
               cnt = cnt - 1;
            end
         end else if (rs == 2) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               mdio_done = 1'b1;
               mdio_rdata = rd_val;
               done_q.push_back(ecount);
               rs = 0;
            end
         end
      end
   end

   // Request/status monitor.
   initial forever begin
      @(negedge sys_clk);
      if (mdio_req && !prev_req) begin
         rise_q.push_back(ecount);
         hold = {mdio_op, mdio_reg_addr,
                 mdio_wdata, mdio_phy_addr};
         w = 1;
      end else if (mdio_req) begin
         w = w + 1;
         if ({mdio_op, mdio_reg_addr, mdio_wdata,
              mdio_phy_addr} != hold)
            viol = viol + 1;
      end else if (prev_req) begin
         width_q.push_back(w);
      end
      if (status_valid) begin
         sv_cnt = sv_cnt + 1;
         if (done_q.size() == 0) sv_bad = sv_bad + 1;
         else if (done_q[$] != ecount - 1) sv_bad = sv_bad + 1;
      end
      prev_req = mdio_req;
   end

   // Model: the transaction the PHY should see for each source.
   function automatic logic [26:0] model_cmd(input int kind);
      logic [26:0] r;
      case (kind)
         0: r = {1'b0, 5'd0, 16'h8000, 5'd1};
         1: r = {1'b0, 5'd4, 16'h01E1, 5'd1};
         2: r = {1'b0, 5'd0, 16'h1200, 5'd1};
         default: r = {1'b1, 5'd1, 16'h0000, 5'd1};
      endcase
      return r;
   endfunction

   function automatic void model_cfg();
      for (int s = 0; s < 4; s++) exp_q.push_back(model_cmd(s));
   endfunction

   function automatic void model_poll();
      exp_q.push_back(model_cmd(4));
   endfunction

   // Expected negedge stamp of the k-th poll request after reset.
   function automatic int poll_stamp(input int k);
      return k * PER + int'(PMAX) + 2;
   endfunction

   task automatic clear_logs();
      acks.delete();
      exp_q.delete();
      rise_q.delete();
      done_q.delete();
      width_q.delete();
      viol = 0;
      sv_cnt = 0;
      sv_bad = 0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      key_flag = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      clear_logs();
   endtask

   task automatic pulse_key();
      key_flag = 1'b1;
      @(negedge sys_clk);
      key_flag = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget,
                            output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge sys_clk);
         if (done_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge sys_clk);
      pulse_key();
      repeat (3) @(negedge sys_clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre_busy got=%b exp=1", busy);
      end
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      total++;
      if (mdio_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_req got=%b exp=0", mdio_req);
      end
      total++;
      if (mdio_op !== 1'b0) begin
         bad++;
         $display("FAIL rst_op got=%b exp=0", mdio_op);
      end
      total++;
      if (mdio_reg_addr !== 5'd0) begin
         bad++;
         $display("FAIL rst_reg got=%h exp=0", mdio_reg_addr);
      end
      total++;
      if (mdio_wdata !== 16'h0000) begin
         bad++;
         $display("FAIL rst_wdata got=%h exp=0", mdio_wdata);
      end
      total++;
      if (mdio_phy_addr !== 5'd1) begin
         bad++;
         $display("FAIL rst_phy got=%h exp=1", mdio_phy_addr);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy got=%b exp=0", busy);
      end
      total++;
      if (status_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_sv got=%b exp=0", status_valid);
      end
      total++;
      if (status_data !== 16'h0000) begin
         bad++;
         $display("FAIL rst_sd got=%h exp=0", status_data);
      end
      total++;
      if (link_up !== 1'b0) begin
         bad++;
         $display("FAIL rst_link got=%b exp=0", link_up);
      end
      sys_rst = 1'b0;
      clear_logs();
      repeat (50) @(negedge sys_clk);
      total++;
      if (rise_q.size() != 0) begin
         bad++;
         $display("FAIL rst_quiet got=%0d exp=0", rise_q.size());
      end
   endtask

   task automatic test_config();
      int k0;
      bit ok;
      do_reset();
      ack_dly = 2;
      done_dly = 10;
      rd_val = 16'h786D;
      @(negedge sys_clk);
      k0 = ecount;
      model_cfg();
      pulse_key();
      wait_done(4, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cfg_timeout got=%0d exp=4", done_q.size());
      end
      total++;
      if (acks.size() != 4) begin
         bad++;
         $display("FAIL cfg_count got=%0d exp=4", acks.size());
      end
      for (int i = 0; i < 4 && i < acks.size(); i++) begin
         total++;
         if (acks[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL cfg_txn%0d got=%h exp=%h",
                     i, acks[i], exp_q[i]);
         end
      end
      total++;
      if (rise_q.size() < 1 || rise_q[0] != k0 + 2) begin
         bad++;
         $display("FAIL cfg_latency got=%0d exp=%0d",
                  rise_q.size() > 0 ? rise_q[0] : -1, k0 + 2);
      end
      for (int i = 1; i < 4 && i < rise_q.size()
           && i <= done_q.size(); i++) begin
         total++;
         if (rise_q[i] != done_q[i-1] + 2) begin
            bad++;
            $display("FAIL cfg_gap%0d got=%0d exp=%0d",
                     i, rise_q[i], done_q[i-1] + 2);
         end
      end
      total++;
      if (status_data !== 16'h786D) begin
         bad++;
         $display("FAIL cfg_sd got=%h exp=786d", status_data);
      end
      total++;
      if (link_up !== 1'b1) begin
         bad++;
         $display("FAIL cfg_link got=%b exp=1", link_up);
      end
      total++;
      if (sv_cnt != 1 || sv_bad != 0) begin
         bad++;
         $display("FAIL cfg_sv got=%0d/%0d exp=1/0",
                  sv_cnt, sv_bad);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL cfg_idle got=%b exp=0", busy);
      end
   endtask

   task automatic test_poll();
      bit ok;
      do_reset();
      ack_dly = 2;
      done_dly = 10;
      rd_val = 16'h7869;
      for (int k = 0; k < 3; k++) model_poll();
      wait_done(3, 600, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL poll_timeout got=%0d exp=3", done_q.size());
      end
      for (int k = 0; k < 3 && k < rise_q.size(); k++) begin
         total++;
         if (rise_q[k] != poll_stamp(k)) begin
            bad++;
            $display("FAIL poll_when%0d got=%0d exp=%0d",
                     k, rise_q[k], poll_stamp(k));
         end
      end
      for (int k = 0; k < 3 && k < acks.size(); k++) begin
         total++;
         if (acks[k] !== exp_q[k]) begin
            bad++;
            $display("FAIL poll_txn%0d got=%h exp=%h",
                     k, acks[k], exp_q[k]);
         end
      end
      total++;
      if (status_data !== 16'h7869) begin
         bad++;
         $display("FAIL poll_sd got=%h exp=7869", status_data);
      end
      total++;
      if (link_up !== 1'b0) begin
         bad++;
         $display("FAIL poll_link got=%b exp=0", link_up);
      end
      total++;
      if (sv_cnt != 3 || sv_bad != 0) begin
         bad++;
         $display("FAIL poll_sv got=%0d/%0d exp=3/0",
                  sv_cnt, sv_bad);
      end
   endtask

   task automatic test_arbitration();
      bit pressed;
      bit ok;
      do_reset();
      ack_dly = 2;
      done_dly = 10;
      rd_val = 16'h786D;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         if (ecount == int'(PMAX)) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL arb_sync got=%0d exp=%0d", ecount, PMAX);
      end
      model_cfg();
      model_poll();
      pulse_key();
      pressed = 1'b0;
      for (int i = 0; i < 400 && ecount < 195; i++) begin
         @(negedge sys_clk);
         if (!pressed && acks.size() == 2) begin
            key_flag = 1'b1;
            pressed = 1'b1;
         end else begin
            key_flag = 1'b0;
         end
      end
      key_flag = 1'b0;
      total++;
      if (acks.size() != 5) begin
         bad++;
         $display("FAIL arb_count got=%0d exp=5", acks.size());
      end
      for (int i = 0; i < 5 && i < acks.size(); i++) begin
         total++;
         if (acks[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL arb_txn%0d got=%h exp=%h",
                     i, acks[i], exp_q[i]);
         end
      end
      total++;
      if (rise_q.size() < 1 || rise_q[0] != int'(PMAX) + 2) begin
         bad++;
         $display("FAIL arb_first got=%0d exp=%0d",
                  rise_q.size() > 0 ? rise_q[0] : -1, PMAX + 2);
      end
      total++;
      if (sv_cnt != 2) begin
         bad++;
         $display("FAIL arb_sv got=%0d exp=2", sv_cnt);
      end
   endtask

   task automatic test_hold();
      bit ok;
      do_reset();
      ack_dly = 50;
      done_dly = 10;
      rd_val = 16'h786D;
      @(negedge sys_clk);
      model_cfg();
      pulse_key();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (rise_q.size() > 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (10) @(negedge sys_clk);
      spur = 1'b1;
      repeat (3) @(negedge sys_clk);
      total++;
      if (!ok || mdio_req !== 1'b1) begin
         bad++;
         $display("FAIL hold_spur got=%b exp=1", mdio_req);
      end
      for (int i = 0; i < 100 && width_q.size() == 0; i++)
         @(negedge sys_clk);
      total++;
      if (width_q.size() < 1 || width_q[0] != 51) begin
         bad++;
         $display("FAIL hold_width got=%0d exp=51",
                  width_q.size() > 0 ? width_q[0] : -1);
      end
      wait_done(4, 400, ok);
      total++;
      if (!ok || viol != 0) begin
         bad++;
         $display("FAIL hold_stable got=%0d exp=0 ok=%0b", viol, ok);
      end
      for (int i = 0; i < 4 && i < acks.size(); i++) begin
         total++;
         if (acks[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL hold_txn%0d got=%h exp=%h",
                     i, acks[i], exp_q[i]);
         end
      end
      total++;
      if (status_data !== 16'h786D) begin
         bad++;
         $display("FAIL hold_sd got=%h exp=786d", status_data);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      ack_dly = 2;
      done_dly = 10;
      rd_val = 16'h786D;
      @(negedge sys_clk);
      pulse_key();
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (acks.size() >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge sys_clk);
      total++;
      if (!ok || busy !== 1'b1 || mdio_wdata !== 16'h01E1) begin
         bad++;
         $display("FAIL mid_pre got=%b/%h exp=1/01e1",
                  busy, mdio_wdata);
      end
      sys_rst = 1'b1;
      @(negedge sys_clk);
      total++;
      if ({mdio_req, busy, mdio_op, status_valid} !== 4'b0000) begin
         bad++;
         $display("FAIL mid_flags got=%b exp=0000",
                  {mdio_req, busy, mdio_op, status_valid});
      end
      total++;
      if ({mdio_reg_addr, mdio_wdata, mdio_phy_addr}
          !== {5'd0, 16'h0000, 5'd1}) begin
         bad++;
         $display("FAIL mid_fields got=%h exp=%h",
                  {mdio_reg_addr, mdio_wdata, mdio_phy_addr},
                  {5'd0, 16'h0000, 5'd1});
      end
      sys_rst = 1'b0;
      clear_logs();
      @(negedge sys_clk);
      model_cfg();
      pulse_key();
      wait_done(4, 200, ok);
      total++;
      if (!ok || acks.size() != 4) begin
         bad++;
         $display("FAIL mid_count got=%0d exp=4", acks.size());
      end
      for (int i = 0; i < 4 && i < acks.size(); i++) begin
         total++;
         if (acks[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL mid_txn%0d got=%h exp=%h",
                     i, acks[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_poll();
      test_arbitration();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_mdio_sequencer.md
# key_mdio_sequencer

Command scheduler between the debounced push-button and the MDIO master. A one-cycle `key_flag` pulse launches a fixed four-step PHY configuration sequence. A free-running timer periodically polls the PHY status register (reg 1). The block arbitrates both sources onto the MDIO master's single request/ack/done handshake and publishes the latest link status.

## Interface
Parameters:
- `PHY_ADDR`, 5'd1: PHY address driven on every request.
- `POLL_MAX`, 26'd49_999_999: poll-timer terminal count; 1 s at 50 MHz.
- `SEQ_LEN`, 3'd4: number of configuration steps executed from the package ROM.

Ports:
- `sys_clk`, in, 1: system clock, 50 MHz.
- `sys_rst`, in, 1: reset, synchronous and active-high.
- `key_flag`, in, 1: debounced key pulse, one cycle wide; launches the config sequence.
- `mdio_req`, out, 1: transaction request to the MDIO master.
- `mdio_op`, out, 1: operation select; 1 = read, 0 = write.
- `mdio_phy_addr`, out, 5: PHY address.
- `mdio_reg_addr`, out, 5: register address.
- `mdio_wdata`, out, 16: write data; 0 for reads.
- `mdio_ack`, in, 1: master accepted the request.
- `mdio_done`, in, 1: transaction complete, one-cycle pulse.
- `mdio_rdata`, in, 16: read data, valid with `mdio_done`.
- `busy`, out, 1: sequencer not in IDLE.
- `status_valid`, out, 1: one-cycle pulse; `status_data` updated.
- `status_data`, out, 16: last value read from reg 1.
- `link_up`, out, 1: `status_data[2]`.

## Operation
- **States:** IDLE, REQ, WAIT_DONE, NEXT.
- **Source latches:**
  - `cfg_pend` sets on `key_flag` whenever no config sequence is in progress.
  - `key_flag` during an active config sequence is dropped.
  - `poll_pend` sets when the poll timer equals `POLL_MAX`.
- **Poll timer:** 26-bit counter; counts every cycle and wraps from `POLL_MAX` to 0. `poll_pend` is sticky until a poll is launched; repeated terminal counts do not stack.
- **IDLE arbitration:** config has strict priority over poll.
  - `cfg_pend` set: clear it, set `step` = 0, set `cfg_active`, go to REQ.
  - Else `poll_pend` set: clear it, load a read of reg 1, go to REQ.
- **REQ:**
  - Drive `mdio_req` = 1 with the fields held stable.
  - On `mdio_ack` = 1, go to WAIT_DONE. `mdio_req` is low from the next cycle.
- **WAIT_DONE:**
  - On `mdio_done`: if the op is a read of reg 1, capture `mdio_rdata` into `status_data` and pulse `status_valid` next cycle.
  - Then go to NEXT.
  - `mdio_done` outside WAIT_DONE is ignored.
- **NEXT:**
  - If `cfg_active` and `step` < `SEQ_LEN`-1: increment `step`, load ROM[`step`+1], go to REQ.
  - Otherwise clear `cfg_active` and go to IDLE.
  - A poll pending during a config sequence waits for IDLE; it is never interleaved.
- **Config ROM:**
  - Step 0: write reg 0 = 16'h8000 (PHY soft reset).
  - Step 1: write reg 4 = 16'h01E1 (advertise 10/100 FD/HD).
  - Step 2: write reg 0 = 16'h1200 (AN enable + restart).
  - Step 3: read reg 1. This step also updates status.
- **Reset mid-operation:** everything returns to reset values immediately, including any outstanding `mdio_req`. Recovering the master is the master's own reset responsibility.

## Timing
- **Reset values:**
  - `mdio_req`, `mdio_op`, `mdio_reg_addr`, `mdio_wdata`: 0.
  - `mdio_phy_addr`: `PHY_ADDR`.
  - `busy`, `status_valid`, `link_up`: 0.
  - `status_data`: 16'h0000.
  - Poll timer, `step`, pending latches: 0.
- **Request issue:**
  - `key_flag` in cycle N while IDLE: `cfg_pend` is set at N+1 and `mdio_req` rises at N+2.
  - A poll terminal count at cycle N gives `mdio_req` at N+2.
- **Ack:** `mdio_ack` combinational-high in the same cycle `mdio_req` rises is legal; the minimum `mdio_req` width is 1 cycle.
- **Done:** `mdio_done` at cycle D gives `status_data`/`status_valid`/`link_up` updated at D+1 and the next `mdio_req` at D+2.
- **Simultaneous events:**
  - `key_flag` and poll terminal count in the same cycle: config is served first, poll after.
  - `key_flag` in the cycle NEXT returns to IDLE: it is accepted.

## Structure
- **Package `mdio_seq_pkg`:** state enum, `OP_READ`/`OP_WRITE` constants, register address constants (`REG_BMCR` = 0, `REG_BMSR` = 1, `REG_ANAR` = 4), config ROM as a constant array of {op, reg, data}.
- **Sub-module `poll_timer`:** counter plus terminal-count pulse, parameterized by `POLL_MAX`. The FSM stays in the top module.

## Test plan
- **Reset:** reset asserted for 3 cycles -> all outputs at reset values; `mdio_req` = 0.
- **Config sequence:** `key_flag` pulse with ack after 2 cycles and done after 10 cycles per transaction, last read `mdio_rdata` = 16'h786D.
  - Required: exactly 4 requests in ROM order (8000 @0, 01E1 @4, 1200 @0, read @1).
  - Required: `status_data` = 16'h786D, `link_up` = 1, `status_valid` single pulse.
- **Poll:** `POLL_MAX` = 100, idle, rdata = 16'h7869 -> read of reg 1 issued every 101 cycles plus handshake delay; `link_up` = 0.
- **Arbitration:** `key_flag` and poll terminal count in the same cycle -> 4 config transactions first, then one poll read. A second `key_flag` mid-sequence -> no extra sequence.
- **Handshake hold:** ack withheld for 50 cycles -> `mdio_req` and all fields stable for 50 cycles. A spurious `mdio_done` during REQ -> ignored.
- **Reset mid-operation:** reset asserted in WAIT_DONE of step 1 -> outputs at reset values next cycle; a subsequent `key_flag` restarts at step 0.
